// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared types and reset constants for the round-robin arbiter.
// The FSM state encoding lives here so future arbiters can reuse it.
package arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

   localparam int unsigned PTR_RST   = 0;
   localparam int unsigned OWNER_RST = 0;

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Request/grant bundle between the requesting FSMs and the arbiter.
// The master side drives requests; the slave side is the arbiter.
interface fsm_rr_arbiter_if #(
   parameter int N_REQ = 4
) ();

   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic [IDW-1:0]   gnt_id;
   logic             gnt_start;
   logic             timeout;

   modport master (
      output req, done,
      input  gnt, gnt_valid, gnt_id, gnt_start, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_valid, gnt_id, gnt_start, timeout
   );

endinterface

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Circular priority encoder: first set request at or after ptr.
// Purely combinational; reusable by other arbiters.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   winner,
   output logic             any
);

   int             w_sum;
   logic [IDW-1:0] w_idx;

   // Scan from the farthest offset down so the nearest hit wins last.
   always_comb begin
      winner = '0;
      w_sum  = 0;
      w_idx  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_sum = int'(ptr) + i;
         if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
         w_idx = IDW'(w_sum);
         if (req[w_idx]) winner = w_idx;
      end
   end

   assign any = |req;

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter FSM with Moore grant and Mealy start/timeout
// pulses; a hold counter forces release after MAX_HOLD cycles.
module fsm_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input logic             clk,
   input logic             reset,
   fsm_rr_arbiter_if.slave arb
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(MAX_HOLD + 1);

   arb_state_t     r_state, w_state_nxt;
   logic [IDW-1:0] r_owner, w_owner_nxt;
   logic [IDW-1:0] r_ptr, w_ptr_nxt;
   logic [CW-1:0]  r_hold_cnt, w_hold_nxt;

   logic [IDW-1:0]   w_win;
   logic             w_any;
   logic             w_last;
   logic             w_req_own;
   logic             w_end;
   logic [N_REQ-1:0] w_gnt;
   logic [IDW-1:0]   w_gnt_id;
   logic             w_gnt_start;
   logic             w_timeout;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (arb.req),
      .ptr    (r_ptr),
      .winner (w_win),
      .any    (w_any)
   );

   assign w_last    = (r_hold_cnt == CW'(MAX_HOLD - 1));
   assign w_req_own = arb.req[r_owner];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= IDW'(OWNER_RST);
         r_ptr      <= IDW'(PTR_RST);
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold_cnt;
      w_end       = 1'b0;
      w_gnt       = '0;
      w_gnt_id    = '0;
      w_gnt_start = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_gnt_start = 1'b1;
               w_state_nxt = GRANT;
               w_owner_nxt = w_win;
               w_hold_nxt  = '0;
            end
         end
         GRANT: begin
            w_gnt[r_owner] = 1'b1;
            w_gnt_id       = r_owner;
            w_hold_nxt     = r_hold_cnt + CW'(1);
            w_end          = arb.done | ~w_req_own | w_last;
            if (w_end) begin
               w_state_nxt = RELEASE;
               w_ptr_nxt   = (r_owner == IDW'(N_REQ - 1)) ?
                             '0 : r_owner + IDW'(1);
               // Timeout only when the hold limit is the sole cause.
               w_timeout   = w_last & ~arb.done & w_req_own;
            end
         end
         RELEASE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // Mealy pulses must stay quiet while reset is held.
      if (reset) begin
         w_gnt_start = 1'b0;
         w_timeout   = 1'b0;
      end
   end

   assign arb.gnt       = w_gnt;
   assign arb.gnt_valid = |w_gnt;
   assign arb.gnt_id    = w_gnt_id;
   assign arb.gnt_start = w_gnt_start;
   assign arb.timeout   = w_timeout;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Self-checking bench for fsm_rr_arbiter: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_fsm_rr_arbiter;

   localparam int N = 4;
   localparam int H = 8;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      bit         done;
      logic [3:0] gnt;
      logic [1:0] id;
      bit         st;
      bit         to;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fsm_rr_arbiter_if #(.N_REQ(N)) bus ();

   fsm_rr_arbiter #(.N_REQ(N), .MAX_HOLD(H)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   int m_own  = -1;
   int m_held = 0;
   int m_next = 0;
   bit m_gap  = 1'b0;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm, input logic [3:0] eg,
                      input logic [1:0] eid, input bit es, input bit et);
      chk({nm, ".gnt"}, 32'(bus.gnt), 32'(eg));
      chk({nm, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|eg));
      chk({nm, ".gnt_id"}, 32'(bus.gnt_id), 32'(eid));
      chk({nm, ".gnt_start"}, 32'(bus.gnt_start), 32'(es));
      chk({nm, ".timeout"}, 32'(bus.timeout), 32'(et));
   endtask

   task automatic cyc(input string nm, input logic [3:0] r, input bit d,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input bit es, input bit et);
      bus.req  = r;
      bus.done = d;
      @(negedge clk);
      cmp(nm, eg, eid, es, et);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req  = '0;
      bus.done = 1'b0;
      reset    = 1'b1;
      #1;
      reset    = 1'b0;
      m_own    = -1;
      m_held   = 0;
      m_next   = 0;
      m_gap    = 1'b0;
   endtask

   // Behavioural reference: who owns the resource, for how long, and
   // where the next round-robin search begins.
   task automatic model(input logic [3:0] r, input bit d,
                        output logic [3:0] eg, output logic [1:0] eid,
                        output bit es, output bit et);
      int cand;
      eg  = '0;
      eid = '0;
      es  = 1'b0;
      et  = 1'b0;
      if (m_own >= 0) begin
         eg  = 4'(1 << m_own);
         eid = 2'(m_own);
         if (m_held + 1 == H && !d && r[m_own]) et = 1'b1;
         if (d || !r[m_own] || m_held + 1 == H) begin
            m_next = (m_own + 1) % N;
            m_own  = -1;
            m_gap  = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            cand = (m_next + k) % N;
            if (!es && r[cand]) begin
               es     = 1'b1;
               m_own  = cand;
               m_held = 0;
            end
         end
      end
   endtask

   initial begin
      logic [3:0] r, eg;
      logic [1:0] eid;
      bit         d, es, et;

      bus.req  = '0;
      bus.done = 1'b0;

      // Single requester, then fairness with everyone requesting.
      tv.push_back('{1, 4'b0010, 0, 4'b0000, 2'd0, 1, 0});
      tv.push_back('{0, 4'b0010, 0, 4'b0010, 2'd1, 0, 0});
      tv.push_back('{0, 4'b0010, 0, 4'b0010, 2'd1, 0, 0});
      tv.push_back('{0, 4'b0010, 1, 4'b0010, 2'd1, 0, 0});
      tv.push_back('{0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0});
      tv.push_back('{0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0});
      for (int k = 0; k < 5; k++) begin
         tv.push_back('{k == 0, 4'b1111, 1, 4'b0000, 2'd0, 1, 0});
         tv.push_back('{0, 4'b1111, 1, 4'(1 << (k % N)), 2'(k % N), 0, 0});
         tv.push_back('{0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0});
      end

      @(negedge clk);
      cmp("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tv[i]) begin
         if (tv[i].rst) do_reset();
         cyc($sformatf("vec%0d", i), tv[i].req, tv[i].done,
             tv[i].gnt, tv[i].id, tv[i].st, tv[i].to);
         if (i == 5) chk("ptr_after_single", 32'(dut.r_ptr), 32'd2);
      end

      do_reset();
      cyc("to_start", 4'b0001, 0, 4'b0000, 2'd0, 1, 0);
      for (int k = 1; k <= H; k++)
         cyc($sformatf("to_hold%0d", k), 4'b0001, 0, 4'b0001, 2'd0, 0, k == H);
      cyc("to_release", 4'b0001, 0, 4'b0000, 2'd0, 0, 0);
      cyc("to_regrant", 4'b0001, 0, 4'b0000, 2'd0, 1, 0);

      for (int k = 1; k <= H; k++)
         cyc($sformatf("co_hold%0d", k), 4'b0001, k == H, 4'b0001, 2'd0, 0, 0);
      cyc("co_drop", 4'b0001, 0, 4'b0000, 2'd0, 0, 0);

      do_reset();
      cyc("dr_start", 4'b1100, 0, 4'b0000, 2'd0, 1, 0);
      cyc("dr_g1", 4'b1100, 0, 4'b0100, 2'd2, 0, 0);
      cyc("dr_g2", 4'b1000, 0, 4'b0100, 2'd2, 0, 0);
      cyc("dr_rel", 4'b1000, 0, 4'b0000, 2'd0, 0, 0);
      cyc("dr_next", 4'b1000, 0, 4'b0000, 2'd0, 1, 0);
      cyc("dr_own3", 4'b1000, 0, 4'b1000, 2'd3, 0, 0);

      do_reset();
      cyc("rm_start", 4'b0100, 0, 4'b0000, 2'd0, 1, 0);
      @(negedge clk);
      cmp("rm_granted", 4'b0100, 2'd2, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      cmp("rm_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      chk("rm_ptr", 32'(dut.r_ptr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("rm_restart", 4'b0100, 0, 4'b0000, 2'd0, 1, 0);
      cyc("rm_regrant", 4'b0100, 0, 4'b0100, 2'd2, 0, 0);

      do_reset();
      r = '0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         d = ($urandom_range(0, 4) == 0);
         bus.req  = r;
         bus.done = d;
         @(negedge clk);
         model(r, d, eg, eid, es, et);
         cmp($sformatf("rnd%0d", c), eg, eid, es, et);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
